dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//  Shares the single data-memory port (dm) between the pipeline CPU MEM stage and a
//  debug/loader requester (UART loader, JTAG-style poke). Sits in sccomp between
//  PipelineCPU (Addr_out/Data_out/mem_w/DMType_out) and dm. CPU has priority; debug
//  is granted on idle CPU cycles, or forcibly after a starvation limit, stalling the CPU.
// PARAMETERS
//  AW          32  address width
//  DW          32  data width
//  STARVE_MAX  15  cycles debug may wait behind a busy CPU before forced grant
//  CNT_W       4   starvation counter width; must hold STARVE_MAX
// PORTS
//  clk         in   1    system clock, all state on rising edge
//  rstn        in   1    asynchronous, active-low reset
//  cpu_req     in   1    CPU MEM stage performs a load/store this cycle
//  cpu_we      in   1    CPU store
//  cpu_addr    in   AW   CPU byte address
//  cpu_wdata   in   DW   CPU store data
//  cpu_type    in   3    CPU DMType (byte/half/word, signed/unsigned)
//  cpu_rdata   out  DW   load data to CPU (combinational from dm_dout)
//  cpu_stall   out  1    CPU must hold MEM stage and all upstream stages this cycle
//  dbg_req     in   1    debug access request; hold req/we/addr/wdata/type until dbg_gnt
//  dbg_we      in   1    debug write
//  dbg_addr    in   AW   debug byte address
//  dbg_wdata   in   DW   debug write data
//  dbg_type    in   3    debug DMType
//  dbg_gnt     out  1    debug access performed on dm this cycle
//  dbg_rvalid  out  1    dbg_rdata valid (one cycle after a read grant)
//  dbg_rdata   out  DW   registered debug read data
//  dm_we       out  1    to dm.DMWr
//  dm_type     out  3    to dm.DMType
//  dm_addr     out  AW   to dm.addr
//  dm_din      out  DW   to dm.din
//  dm_dout     in   DW   from dm.dout (combinational read)
// BEHAVIOUR
//  - FSM, 2 states: S_CPU (CPU owns dm), S_DBG (debug owns dm, exactly 1 cycle).
//  - S_CPU: dm_* = cpu_* (dm_we = cpu_req & cpu_we); dbg_gnt=0; cpu_stall=0.
//    next = S_DBG if dbg_req & (~cpu_req | starve_cnt==STARVE_MAX), else S_CPU.
//  - S_DBG: dm_* = dbg_* (dm_we = dbg_req & dbg_we); dbg_gnt = dbg_req;
//    cpu_stall = cpu_req; next = S_CPU unconditionally (debug gets at most every 2nd cycle).
//  - starve_cnt: in S_CPU, +1 when dbg_req & cpu_req, saturating at STARVE_MAX; cleared
//    to 0 on entering S_DBG and whenever dbg_req=0.
//  - Grant latency: 1 cycle after dbg_req seen with CPU idle; worst case STARVE_MAX+1.
//  - Decision is registered: CPU becoming busy in the S_DBG cycle is stalled 1 cycle;
//    CPU never stalls more than 1 consecutive cycle.
//  - Read return: on a read grant, dbg_rdata <= dm_dout, dbg_rvalid=1 next cycle only;
//    dbg_rdata holds until the next read grant. Writes give no rvalid.
//  - dbg_req dropped while in S_DBG (protocol violation): no dm write, dbg_gnt=0,
//    no rvalid, return to S_CPU.
//  - cpu_rdata = dm_dout always; CPU ignores it while cpu_stall=1.
//  - Reset (async, any state): state=S_CPU, starve_cnt=0, dbg_rvalid=0, dbg_rdata=0;
//    while rstn=0, dm_we=0, dbg_gnt=0, cpu_stall=0 regardless of inputs.
// STRUCTURE
//  - Shared header dm_defs: DMType codes, S_CPU/S_DBG state encoding.
//  - One natural sub-module: sat_counter (CNT_W, MAX, inc, clr) for starve_cnt.
//  - Top integration: PipelineCPU gains a stall input driven by cpu_stall.
// TESTING
//  1 rstn=0 with cpu_req=1,cpu_we=1 -> dm_we=0, dbg_gnt=0, dbg_rvalid=0, dbg_rdata=0.
//  2 CPU idle, dbg write 0xDEADBEEF @0x40 word -> dbg_gnt 1 cycle after req, dm_we=1,
//    dm_addr=0x40; CPU lw 0x40 later returns 0xDEADBEEF; dbg_rvalid stays 0.
//  3 CPU req every cycle, dbg read @0x40 from cycle 0 -> dbg_gnt only at cycle 16,
//    cpu_stall=1 at cycle 16 only, dbg_rvalid=1 with 0xDEADBEEF at cycle 17.
//  4 Grant decided with CPU idle, CPU sw 0x12345678 @0x80 in grant cycle -> cpu_stall=1
//    one cycle, dm sees dbg access, CPU store commits next cycle; both values read back.
//  5 dbg_req deasserted in S_DBG (dbg_we=1) -> dm_we=0, dbg_gnt=0, memory unchanged.
//  6 rstn asserted mid-S_DBG -> dbg_gnt and cpu_stall drop without clock edge;
//    after release, first cycle is S_CPU, starve_cnt=0.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Contents:
//   dm_type_e   - DMType access-size codes as seen by dm
//   arb_state_e - arbiter ownership state encoding
//   DefAW/DefDW - default address/data widths
package dm_arbiter_pkg;

  localparam int unsigned DefAW = 32;
  localparam int unsigned DefDW = 32;

  typedef enum logic [2:0] {
    DmWord  = 3'b000,
    DmHalf  = 3'b001,
    DmHalfU = 3'b010,
    DmByte  = 3'b011,
    DmByteU = 3'b100
  } dm_type_e;

  // StCpu: pipeline owns dm. StDbg: debug owns dm for exactly one cycle.
  typedef enum logic {
    StCpu = 1'b0,
    StDbg = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of the three port groups around the data-memory arbiter.
// CPU group : cpu_req/we/addr/wdata/type in, cpu_rdata/cpu_stall out
// Debug group: dbg_req/we/addr/wdata/type in, dbg_gnt/rvalid/rdata out
// Memory group: dm_we/type/addr/din out, dm_dout in (combinational read)
// Modports: slave = arbiter side, master = requesters plus memory side.
interface dm_arbiter_if
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned AW = DefAW,
  parameter int unsigned DW = DefDW
) ();

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  dm_type_e      cpu_type;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  dm_type_e      dbg_type;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic          dm_we;
  dm_type_e      dm_type;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_din;
  logic [DW-1:0] dm_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_type,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_type,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output dm_we, dm_type, dm_addr, dm_din,
    input  dm_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_type,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_type,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  dm_we, dm_type, dm_addr, dm_din,
    output dm_dout
  );

endinterface

// File: rtl/dm_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports:
//   clk  - clock
//   rstn - asynchronous active-low reset, count -> 0
//   inc  - count up by one, holding at MAX
//   clr  - force count to 0
//   cnt  - current count
module dm_arbiter_sat_counter #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned MAX   = 15
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single data-memory port between the CPU MEM stage and a debug/loader
// requester. The CPU has priority; debug is granted on an idle CPU cycle or, after
// STARVE_MAX cycles of waiting behind a busy CPU, forcibly for one cycle while the
// CPU is stalled. Debug can own dm at most every second cycle.
// Ports:
//   clk  - clock, all state on rising edge
//   rstn - asynchronous active-low reset
//   bus  - dm_arbiter_if.slave carrying the CPU, debug and dm groups
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned AW         = DefAW,
  parameter int unsigned DW         = DefDW,
  parameter int unsigned STARVE_MAX = 15,
  parameter int unsigned CNT_W      = 4
) (
  input  logic            clk,
  input  logic            rstn,
  dm_arbiter_if.slave     bus
);

  arb_state_e       state_q, state_d;
  logic             is_dbg;
  logic             rd_grant;
  logic             starve_inc, starve_clr;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic [AW-1:0]    addr_mux;
  logic [DW-1:0]    din_mux;
  logic             rvalid_q;
  logic [DW-1:0]    rdata_q;

  assign is_dbg  = (state_q == StDbg);
  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    state_d = StCpu;
    if (!is_dbg && bus.dbg_req && (!bus.cpu_req || starved)) begin
      state_d = StDbg;
    end
  end

  // Count only cycles where debug waits behind a busy CPU; any gap in dbg_req or a
  // grant restarts the wait.
  assign starve_inc = !is_dbg && bus.dbg_req && bus.cpu_req;
  assign starve_clr = !bus.dbg_req || (!is_dbg && (state_d == StDbg));

  dm_arbiter_sat_counter #(
    .CNT_W (CNT_W),
    .MAX   (STARVE_MAX)
  ) u_starve_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (starve_inc),
    .clr  (starve_clr),
    .cnt  (starve_cnt)
  );

  // A debug grant with dbg_req already dropped performs nothing.
  assign rd_grant = is_dbg && bus.dbg_req && !bus.dbg_we;

  always_comb begin
    addr_mux    = is_dbg ? bus.dbg_addr  : bus.cpu_addr;
    din_mux     = is_dbg ? bus.dbg_wdata : bus.cpu_wdata;
    bus.dm_addr = addr_mux;
    bus.dm_din  = din_mux;
    bus.dm_type = is_dbg ? bus.dbg_type : bus.cpu_type;
    // rstn gates the side-effecting strobes so nothing fires while reset is held.
    bus.dm_we   = rstn && (is_dbg ? (bus.dbg_req && bus.dbg_we) : (bus.cpu_req && bus.cpu_we));
    bus.dbg_gnt = rstn && is_dbg && bus.dbg_req;
    bus.cpu_stall  = rstn && is_dbg && bus.cpu_req;
    bus.cpu_rdata  = bus.dm_dout;
    bus.dbg_rvalid = rvalid_q;
    bus.dbg_rdata  = rdata_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StCpu;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rd_grant;
      if (rd_grant) begin
        rdata_q <= bus.dm_dout;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  typedef struct {
    int          cyc;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
  } gnt_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rv_exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  gnt_exp_t    exp_gnt[$];
  rv_exp_t     exp_rv[$];
  logic [31:0] exp_load[$];
  logic [31:0] mem [0:255];

  dm_arbiter_if #(.AW(32), .DW(32)) bus ();

  dm_arbiter #(
    .AW         (32),
    .DW         (32),
    .STARVE_MAX (15),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word-addressed memory model with combinational read.
  assign bus.dm_dout = mem[bus.dm_addr[9:2]];
  always @(posedge clk) if (bus.dm_we) mem[bus.dm_addr[9:2]] <= bus.dm_din;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a grant, read data or load.
  gnt_exp_t ge;
  rv_exp_t  re;
  logic [31:0] le;
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.dbg_gnt) begin
        if (exp_gnt.size() == 0) begin
          check("unexpected_gnt", 32'd1, 32'd0);
        end else begin
          ge = exp_gnt.pop_front();
          check("gnt_cycle", cyc, ge.cyc);
          check("gnt_dm_we", {31'd0, bus.dm_we}, {31'd0, ge.we});
          check("gnt_dm_addr", bus.dm_addr, ge.addr);
          if (ge.we) check("gnt_dm_din", bus.dm_din, ge.wdata);
          check("gnt_cpu_stall", {31'd0, bus.cpu_stall}, {31'd0, ge.stall});
        end
      end else if (bus.cpu_stall) begin
        check("stall_without_gnt", 32'd1, 32'd0);
      end
      if (bus.dbg_rvalid) begin
        if (exp_rv.size() == 0) begin
          check("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          re = exp_rv.pop_front();
          check("rvalid_cycle", cyc, re.cyc);
          check("dbg_rdata", bus.dbg_rdata, re.data);
        end
      end
      if (bus.cpu_req && !bus.cpu_we && !bus.cpu_stall) begin
        if (exp_load.size() == 0) begin
          check("unexpected_load", 32'd1, 32'd0);
        end else begin
          le = exp_load.pop_front();
          check("cpu_rdata", bus.cpu_rdata, le);
        end
      end
    end
  end

  // Holds a CPU access until a non-stalled cycle completes; returns at posedge+1.
  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] data);
    logic stalled;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = we ? data : 32'd0;
    bus.cpu_type  = DmWord;
    if (!we) exp_load.push_back(data);
    for (int k = 0; k < 4; k++) begin
      #1;
      stalled = bus.cpu_stall;
      @(posedge clk);
      #1;
      if (!stalled) return;
    end
    check("cpu_stall_bound", 32'd1, 32'd0);
  endtask

  // Holds a debug request until granted, drops it after the grant cycle.
  task automatic dbg_access(input logic we, input logic [31:0] addr, input logic [31:0] data);
    bit got = 0;
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = we;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = data;
    bus.dbg_type  = DmWord;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.dbg_gnt) begin
        got = 1;
        break;
      end
    end
    if (!got) check("dbg_grant_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.dbg_req = 1'b0;
  endtask

  // Debug read behind a CPU storing every cycle: forced grant after 16 cycles.
  task automatic starve_run(input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic [31:0] base);
    int t0 = cyc;
    exp_gnt.push_back('{cyc: t0 + 16, we: 1'b0, addr: addr, wdata: 32'd0, stall: 1'b1});
    exp_rv.push_back('{cyc: t0 + 17, data: exp_data});
    fork
      dbg_access(1'b0, addr, 32'd0);
      begin
        for (int i = 0; i < 20; i++) cpu_op(1'b1, base + 32'(4 * i), 32'hA000_0000 + 32'(i));
        bus.cpu_req = 1'b0;
      end
      begin
        #2;
        check("first_cycle_no_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
        check("first_cycle_no_stall", {31'd0, bus.cpu_stall}, 32'd0);
      end
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    rstn = 1'b0;
    bus.cpu_req = 1'b1;  bus.cpu_we = 1'b1;  bus.cpu_addr = 32'h10;
    bus.cpu_wdata = 32'h1111_1111;  bus.cpu_type = DmWord;
    bus.dbg_req = 1'b1;  bus.dbg_we = 1'b1;  bus.dbg_addr = 32'h20;
    bus.dbg_wdata = 32'h2222_2222;  bus.dbg_type = DmWord;

    // 1: reset holds every strobe low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_dm_we", {31'd0, bus.dm_we}, 32'd0);
    check("rst_dbg_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
    check("rst_cpu_stall", {31'd0, bus.cpu_stall}, 32'd0);
    check("rst_dbg_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
    check("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // 2: debug write with CPU idle, granted the next cycle.
    t0 = cyc;
    exp_gnt.push_back('{cyc: t0 + 1, we: 1'b1, addr: 32'h40, wdata: 32'hDEAD_BEEF, stall: 1'b0});
    dbg_access(1'b1, 32'h40, 32'hDEAD_BEEF);
    cpu_op(1'b0, 32'h40, 32'hDEAD_BEEF);
    bus.cpu_req = 1'b0;
    check("write_no_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);

    // 3: starvation-forced debug read; stalled CPU store retried afterwards.
    starve_run(32'h40, 32'hDEAD_BEEF, 32'h100);
    cpu_op(1'b0, 32'h140, 32'hA000_0010);
    cpu_op(1'b0, 32'h14C, 32'hA000_0013);
    bus.cpu_req = 1'b0;

    // 4: CPU store arrives in the grant cycle and is stalled one cycle.
    t0 = cyc;
    exp_gnt.push_back('{cyc: t0 + 1, we: 1'b1, addr: 32'h84, wdata: 32'hCAFE_F00D, stall: 1'b1});
    fork
      dbg_access(1'b1, 32'h84, 32'hCAFE_F00D);
      begin
        @(posedge clk);
        #1;
        cpu_op(1'b1, 32'h80, 32'h1234_5678);
        bus.cpu_req = 1'b0;
      end
    join
    check("rdata_holds", bus.dbg_rdata, 32'hDEAD_BEEF);
    cpu_op(1'b0, 32'h84, 32'hCAFE_F00D);
    cpu_op(1'b0, 32'h80, 32'h1234_5678);
    bus.cpu_req = 1'b0;
    t0 = cyc;
    exp_gnt.push_back('{cyc: t0 + 1, we: 1'b0, addr: 32'h80, wdata: 32'd0, stall: 1'b0});
    exp_rv.push_back('{cyc: t0 + 2, data: 32'h1234_5678});
    dbg_access(1'b0, 32'h80, 32'd0);

    // 5: dbg_req dropped in the debug cycle: nothing is written.
    bus.dbg_req = 1'b1;  bus.dbg_we = 1'b1;  bus.dbg_addr = 32'h40;
    bus.dbg_wdata = 32'h5555_5555;
    @(posedge clk);
    #1;
    bus.dbg_req = 1'b0;
    #1;
    check("drop_dm_we", {31'd0, bus.dm_we}, 32'd0);
    check("drop_dbg_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
    @(posedge clk);
    #1;
    check("drop_no_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
    cpu_op(1'b0, 32'h40, 32'hDEAD_BEEF);
    bus.cpu_req = 1'b0;
    check("drop_mem_unchanged", mem[32'h40 >> 2], 32'hDEAD_BEEF);

    // 6: reset in the middle of a debug cycle.
    bus.dbg_req = 1'b1;  bus.dbg_we = 1'b0;  bus.dbg_addr = 32'h40;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b1;  bus.cpu_we = 1'b0;  bus.cpu_addr = 32'h84;
    #1;
    check("pre_rst_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
    check("pre_rst_stall", {31'd0, bus.cpu_stall}, 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_gnt", {31'd0, bus.dbg_gnt}, 32'd0);
    check("mid_rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
    check("mid_rst_dm_we", {31'd0, bus.dm_we}, 32'd0);
    check("mid_rst_rvalid", {31'd0, bus.dbg_rvalid}, 32'd0);
    check("mid_rst_rdata", bus.dbg_rdata, 32'd0);
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    starve_run(32'h84, 32'hCAFE_F00D, 32'h200);

    repeat (3) @(posedge clk);
    #1;
    check("gnt_queue_empty", exp_gnt.size(), 32'd0);
    check("rv_queue_empty", exp_rv.size(), 32'd0);
    check("load_queue_empty", exp_load.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
